// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

    localparam int ARB_DATA_W = 64;

    localparam logic REQ_IF   = 1'b0;
    localparam logic REQ_DATA = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-port signal bundle for mem_port_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if;

    logic                                req0, req1;
    logic [mem_arb_pkg::ARB_DATA_W-1:0]  addr0, addr1;
    logic [mem_arb_pkg::ARB_DATA_W-1:0]  wdata0, wdata1;
    logic                                we0, we1;
    logic                                gnt0, gnt1;
    logic                                rvalid0, rvalid1;
    logic [mem_arb_pkg::ARB_DATA_W-1:0]  rdata;

    logic                                mem_valid;
    logic                                mem_ready;
    logic [mem_arb_pkg::ARB_DATA_W-1:0]  mem_addr, mem_wdata;
    logic                                mem_we;
    logic                                mem_rvalid;
    logic [mem_arb_pkg::ARB_DATA_W-1:0]  mem_rdata;

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
        output mem_valid, mem_addr, mem_wdata, mem_we,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
        input  mem_valid, mem_addr, mem_wdata, mem_we,
        output mem_ready, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_mux2.sv
// 64-bit 2:1 steering mux used for the memory port payload.
module mux2
    import mem_arb_pkg::*;
(
    input  logic                  sel,
    input  logic [ARB_DATA_W-1:0] a,
    input  logic [ARB_DATA_W-1:0] b,
    output logic [ARB_DATA_W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the shared 64-bit memory port.
// Define MEM_ARB_FIXED_PRIO_EN to give requester 1 fixed priority instead of round-robin.
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    mem_port_arbiter_if.slave bus
);

    arb_state_t             state, state_nxt;
    logic                   owner, owner_nxt;
    logic                   winner;
    logic                   any_req;
    logic [ARB_DATA_W-1:0]  addr_sel, wdata_sel;

    assign any_req = bus.req0 | bus.req1;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign winner = bus.req1;
`else
    logic last;

    // Ties go to the requester that was not accepted most recently.
    assign winner = (bus.req0 & bus.req1) ? ~last : bus.req1;

    always_ff @(posedge clk) begin
        if (reset)
            last <= REQ_DATA;
        else if (state == ARB_ISSUE && bus.mem_ready)
            last <= owner;
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
            owner <= REQ_IF;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        bus.mem_valid = 1'b0;
        bus.gnt0      = 1'b0;
        bus.gnt1      = 1'b0;
        bus.rvalid0   = 1'b0;
        bus.rvalid1   = 1'b0;
        bus.rdata     = '0;

        case (state)
            ARB_IDLE: begin
                if (any_req) begin
                    state_nxt = ARB_ISSUE;
                    owner_nxt = winner;
                end
            end
            ARB_ISSUE: begin
                bus.mem_valid = 1'b1;
                if (bus.mem_ready) begin
                    bus.gnt0  = (owner == REQ_IF);
                    bus.gnt1  = (owner == REQ_DATA);
                    state_nxt = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                // Response and re-arbitration share one edge, so back-to-back issue has no bubble.
                if (bus.mem_rvalid) begin
                    bus.rvalid0 = (owner == REQ_IF);
                    bus.rvalid1 = (owner == REQ_DATA);
                    bus.rdata   = bus.mem_rdata;
                    if (any_req) begin
                        state_nxt = ARB_ISSUE;
                        owner_nxt = winner;
                    end else begin
                        state_nxt = ARB_IDLE;
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    mux2 u_addr_mux (
        .sel (owner),
        .a   (bus.addr0),
        .b   (bus.addr1),
        .y   (addr_sel)
    );

    mux2 u_wdata_mux (
        .sel (owner),
        .a   (bus.wdata0),
        .b   (bus.wdata1),
        .y   (wdata_sel)
    );

    assign bus.mem_addr  = (state == ARB_ISSUE) ? addr_sel  : '0;
    assign bus.mem_wdata = (state == ARB_ISSUE) ? wdata_sel : '0;
    assign bus.mem_we    = (state == ARB_ISSUE) & (owner ? bus.we1 : bus.we0);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter: cycle table plus tie, idle and reset sequences.
module tb_mem_port_arbiter;

    localparam logic [63:0] A0 = 64'h100;
    localparam logic [63:0] D0 = 64'h1111;
    localparam logic [63:0] A1 = 64'h200;
    localparam logic [63:0] D1 = 64'h55;

    typedef struct {
        logic        req0, req1, rdy, rv;
        logic [63:0] mrd;
        logic        g0, g1, v0, v1, mv, mwe;
        logic [63:0] rd, ma, mwd;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [197:0] outs();
        return {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_valid, bus.mem_we,
                bus.rdata, bus.mem_addr, bus.mem_wdata};
    endfunction

    task automatic check(input string name, input logic [197:0] act, input logic [197:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r0, input logic r1, input logic rdy, input logic rv,
                         input logic [63:0] mrd);
        @(negedge clk);
        bus.req0       = r0;
        bus.req1       = r1;
        bus.mem_ready  = rdy;
        bus.mem_rvalid = rv;
        bus.mem_rdata  = mrd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t tbl [15];

    initial begin
        logic exp_g [4];
        logic [1:0] g;
        logic last_g;
        int   ngnt;
        logic tie_winner;

`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
        tie_winner = 1'b1;
`else
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
        tie_winner = 1'b0;
`endif

        tbl = '{
            '{0,0,0,0,64'h0,     0,0,0,0,0,0, 64'h0,     64'h0,64'h0},
            '{1,0,0,0,64'h0,     0,0,0,0,0,0, 64'h0,     64'h0,64'h0},
            '{1,0,1,0,64'h0,     1,0,0,0,1,0, 64'h0,     A0,   D0},
            '{0,0,0,1,64'hDEAD,  0,0,1,0,0,0, 64'hDEAD,  64'h0,64'h0},
            '{0,0,0,0,64'h0,     0,0,0,0,0,0, 64'h0,     64'h0,64'h0},
            '{0,1,0,0,64'h0,     0,0,0,0,0,0, 64'h0,     64'h0,64'h0},
            '{0,1,0,0,64'h0,     0,0,0,0,1,1, 64'h0,     A1,   D1},
            '{1,1,0,1,64'hF00,   0,0,0,0,1,1, 64'h0,     A1,   D1},
            '{1,1,0,0,64'h0,     0,0,0,0,1,1, 64'h0,     A1,   D1},
            '{1,1,1,0,64'h0,     0,1,0,0,1,1, 64'h0,     A1,   D1},
            '{1,0,0,1,64'h77,    0,0,0,1,0,0, 64'h77,    64'h0,64'h0},
            '{1,0,1,0,64'h0,     1,0,0,0,1,0, 64'h0,     A0,   D0},
            '{0,0,0,0,64'h0,     0,0,0,0,0,0, 64'h0,     64'h0,64'h0},
            '{0,0,0,1,64'h1234,  0,0,1,0,0,0, 64'h1234,  64'h0,64'h0},
            '{0,0,0,1,64'h9999,  0,0,0,0,0,0, 64'h0,     64'h0,64'h0}
        };

        reset = 1'b1;
        bus.addr0 = A0; bus.wdata0 = D0; bus.we0 = 1'b0;
        bus.addr1 = A1; bus.wdata1 = D1; bus.we1 = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

        // Idle after reset: nothing moves even with mem_rvalid toggling.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b0, i[1], i[0], 64'hA5A5_0000 + 64'(i));
            check($sformatf("idle[%0d]", i), outs(), '0);
        end

        // Cycle table: single read, write backpressure, back-to-back, ignored late rvalid.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].req0, tbl[i].req1, tbl[i].rdy, tbl[i].rv, tbl[i].mrd);
            check($sformatf("vec[%0d]", i), outs(),
                  {tbl[i].g0, tbl[i].g1, tbl[i].v0, tbl[i].v1, tbl[i].mv, tbl[i].mwe,
                   tbl[i].rd, tbl[i].ma, tbl[i].mwd});
        end

        // Both requesters held, ready always high, response one cycle after each grant.
        do_reset();
        ngnt   = 0;
        last_g = 1'b0;
        for (int c = 0; c < 20 && ngnt < 4; c++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b1, 64'hC0 + 64'(c));
            if (c == 0)
                check("tie_idle", outs(), '0);
            g = {bus.gnt1, bus.gnt0};
            if (bus.rvalid0 | bus.rvalid1)
                check($sformatf("tie_rvalid_owner[%0d]", c), 198'({bus.rvalid1, bus.rvalid0}),
                      198'(last_g ? 2'b10 : 2'b01));
            if (g != 2'b00) begin
                check($sformatf("tie_gnt[%0d]", ngnt), 198'(g), 198'(exp_g[ngnt] ? 2'b10 : 2'b01));
                last_g = exp_g[ngnt];
                ngnt++;
            end
        end
        check("tie_gnt_count", 198'(ngnt), 198'(4));
        apply(1'b0, 1'b0, 1'b0, 1'b1, 64'hE0);
        check("tie_drain", outs(), {2'b00, ~last_g, last_g, 2'b00, 64'hE0, 128'h0});

        // Reset while waiting: the late response is dropped and the tie order restarts.
        do_reset();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        apply(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
        check("rst_pre_gnt0", 198'({bus.gnt0, bus.gnt1}), 198'(2'b10));
        apply(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'hBAD;
        #1;
        check("rst_late_rvalid", outs(), '0);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
        check("rst_idle", outs(), '0);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        check("rst_tie_gnt", 198'({bus.gnt1, bus.gnt0}), 198'(tie_winner ? 2'b10 : 2'b01));
        apply(1'b0, 1'b0, 1'b0, 1'b1, 64'h42);
        check("rst_tie_rvalid", 198'({bus.rvalid1, bus.rvalid0, bus.rdata}),
              198'({tie_winner, ~tie_winner, 64'h42}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
